// File: rtl/puf_response_voter_if.sv
// Handshake and PUF-facing signal bundle for puf_response_voter.
// The slave modport is the voter's view; master is the requester/PUF side.
interface puf_response_voter_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_challenge;
  logic [7:0] puf_chall;
  logic       puf_en;
  logic       puf_rst;
  logic [7:0] puf_response;
  logic       puf_ready;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [7:0] rsp_unstable;
  logic       rsp_timeout;
  logic       busy;

  modport slave (
    input  req_valid, req_challenge, puf_response, puf_ready, rsp_ready,
    output req_ready, puf_chall, puf_en, puf_rst, rsp_valid, rsp_data,
           rsp_unstable, rsp_timeout, busy
  );

  modport master (
    output req_valid, req_challenge, puf_response, puf_ready, rsp_ready,
    input  req_ready, puf_chall, puf_en, puf_rst, rsp_valid, rsp_data,
           rsp_unstable, rsp_timeout, busy
  );
endinterface

// File: rtl/puf_response_voter.sv
// Evaluates a PUF NUM_EVALS times per challenge (resetting it between runs)
// and returns the per-bit majority vote plus a per-bit disagreement mask.
module puf_response_voter #(
  parameter int NUM_EVALS = 5,
  parameter int TIMEOUT   = 4096
) (
  input logic                  clk,
  input logic                  rst,
  puf_response_voter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  localparam logic [3:0]  EVALS     = 4'(NUM_EVALS);
  localparam logic [3:0]  HALF      = 4'(NUM_EVALS / 2);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic        clr_cnt;
  logic [15:0] wait_cnt;
  logic [3:0]  eval_cnt;
  logic [3:0]  ones      [8];
  logic [3:0]  ones_next [8];
  logic [7:0]  vote;
  logic [7:0]  unstable;

  // Vote on the counts as they will be after the current capture, so the
  // final result can be registered on the same edge that enters DONE.
  always_comb begin
    // NOTE: every element is assigned on every pass, so no latch is inferred.
    for (int i = 0; i < 8; i++) begin
      ones_next[i] = ones[i] + {3'b000, bus.puf_response[i]};
      vote[i]      = ones_next[i] > HALF;
      unstable[i]  = (ones_next[i] != 4'd0) && (ones_next[i] != EVALS);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      clr_cnt          <= 1'b0;
      wait_cnt         <= '0;
      eval_cnt         <= '0;
      // NOTE: ones is a small register array, not a RAM, so it takes the reset.
      for (int i = 0; i < 8; i++) ones[i] <= '0;
      bus.req_ready    <= 1'b1;
      bus.puf_rst      <= 1'b1;
      bus.puf_en       <= 1'b0;
      bus.puf_chall    <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_data     <= '0;
      bus.rsp_unstable <= '0;
      bus.rsp_timeout  <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments only; outputs are set on the
      // transition so they are registered copies of the next state's decode.
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            state         <= CLEAR;
            bus.puf_chall <= bus.req_challenge;
            for (int i = 0; i < 8; i++) ones[i] <= '0;
            eval_cnt      <= '0;
            clr_cnt       <= 1'b0;
            bus.req_ready <= 1'b0;
            bus.busy      <= 1'b1;
          end
        end

        CLEAR: begin
          clr_cnt <= 1'b1;
          if (clr_cnt) begin
            state       <= RUN;
            wait_cnt    <= '0;
            bus.puf_rst <= 1'b0;
            bus.puf_en  <= 1'b1;
          end
        end

        RUN: begin
          wait_cnt <= wait_cnt + 16'd1;
          // A capture in the timeout cycle wins over the abort.
          if (bus.puf_ready) begin
            for (int i = 0; i < 8; i++) ones[i] <= ones_next[i];
            eval_cnt    <= eval_cnt + 4'd1;
            clr_cnt     <= 1'b0;
            bus.puf_en  <= 1'b0;
            bus.puf_rst <= 1'b1;
            if (eval_cnt + 4'd1 == EVALS) begin
              state            <= DONE;
              bus.rsp_data     <= vote;
              bus.rsp_unstable <= unstable;
              bus.rsp_timeout  <= 1'b0;
              bus.rsp_valid    <= 1'b1;
              bus.busy         <= 1'b0;
            end else begin
              state <= CLEAR;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state            <= DONE;
            bus.rsp_data     <= '0;
            bus.rsp_unstable <= '0;
            bus.rsp_timeout  <= 1'b1;
            bus.rsp_valid    <= 1'b1;
            bus.busy         <= 1'b0;
            bus.puf_en       <= 1'b0;
            bus.puf_rst      <= 1'b1;
          end
        end

        DONE: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
